node_path_sequencer: RTL and testbench
======================================

NODE_PATH_SEQUENCER -- requirements
Module: node_path_sequencer

Interface
REQ-001 Parameter THRESH_HI, default 1200, meaning sensor value above which a sensor reads "on line".
REQ-002 Parameter THRESH_LO, default 700, meaning sensor value below which a sensor reads "off line".
REQ-003 Parameter DEBOUNCE, default 3, meaning consecutive all-high samples required to confirm a node.
REQ-004 Parameter TURN_MIN, default 8, meaning minimum samples spent pivoting before line reacquisition is accepted.
REQ-005 Parameter LOST_LIMIT, default 16, meaning consecutive all-low samples before a search starts (REQ-030 only).
REQ-006 Ports, clock and reset first: clk_50M in 1, the single clock; reset in 1, asynchronous active-high reset.
REQ-007 Ports: left, middle, right in 12 each, LFA sensor values; sample_valid in 1, one-cycle strobe marking a new sensor triple.
REQ-008 Ports: path_wr_en in 1, path_wr_addr in 4, path_wr_data in 2, path memory write (00 straight, 01 left, 10 right, 11 stop).
REQ-009 Ports: start in 1, one-cycle run request.
REQ-010 Ports: m1_a, m1_b, m2_a, m2_b out 1 each, motor direction bits (a=1,b=0 forward; a=0,b=1 reverse; 0,0 stopped).
REQ-011 Ports: dc1, dc2 out 4 each, left/right duty cycle; node_count out 4; busy out 1; done out 1.

Function
REQ-012 Path memory SHALL be 16 x 2 bits; a write takes effect on the clk_50M edge with path_wr_en high, only while busy=0; writes while busy=1 SHALL be ignored.
REQ-013 States SHALL be IDLE, FOLLOW, CONFIRM, TURN, EXIT, DONE (plus SEARCH under REQ-030).
REQ-014 IDLE: motors stopped, dc1=dc2=0, busy=0; start=1 -> FOLLOW, node_count<=0, done<=0, busy<=1; start while busy=1 SHALL be ignored.
REQ-015 Sensor classification and all state decisions SHALL occur only on cycles with sample_valid=1; outputs SHALL hold between strobes.
REQ-016 FOLLOW, middle-only (middle>HI, left<LO, right<LO): both forward, dc1=8, dc2=8.
REQ-017 FOLLOW, right>HI and left<LO: both forward, dc1=10, dc2=2; left>HI and right<LO: both forward, dc1=2, dc2=10.
REQ-018 FOLLOW, any other non-node pattern: hold previous motor and duty outputs.
REQ-019 FOLLOW, all three >HI -> CONFIRM with debounce count 1; CONFIRM increments on each further all-high sample, returns to FOLLOW on any non-all-high sample, and at count=DEBOUNCE performs the node action.
REQ-020 Node action: fetch path[node_count], then node_count<=node_count+1 (saturating at 15); code 11 -> DONE; 00 -> EXIT; 01/10 -> TURN.
REQ-021 TURN left: m1 reverse, m2 forward; TURN right: m1 forward, m2 reverse; dc1=dc2=8; exits to FOLLOW once at least TURN_MIN samples elapsed and middle-only pattern is seen.
REQ-022 EXIT: both forward dc1=dc2=8; -> FOLLOW on the first sample that is not all-high.
REQ-023 Node at path index 15 with non-stop code SHALL execute that code, then the next confirmed node forces DONE (no wrap).
REQ-024 DONE: motors stopped, dc1=dc2=0, done=1, busy=0; start -> FOLLOW as in REQ-014.
REQ-025 Duty values SHALL be constants only; no arithmetic on dc1/dc2 may wrap below 0 or above 15.
REQ-026 sample_valid and path_wr_en in the same cycle SHALL both be honoured (write ignored if busy).

Reset
REQ-027 reset=1 SHALL asynchronously force IDLE, motors 0, dc1=dc2=0, node_count=0, busy=0, done=0, all counters 0.
REQ-028 Path memory contents SHALL NOT be cleared by reset; reset mid-run SHALL abort the run with no further node actions.

Configuration
REQ-029 Without LF_LOST_RECOVERY_EN, an all-low pattern in FOLLOW SHALL hold outputs indefinitely (REQ-018).
REQ-030 With LF_LOST_RECOVERY_EN, LOST_LIMIT consecutive all-low samples in FOLLOW -> SEARCH: pivot toward side of the last non-middle-only correction (default right), dc1=dc2=6; any middle>HI sample -> FOLLOW; search does not alter node_count.

Verification
REQ-031 Path {01,11}, start, middle-only samples -> FOLLOW, dc1=dc2=8, m1_a=m2_a=1, busy=1.
REQ-032 Then 3 all-high samples -> node_count=1, TURN left (m1_b=1, m2_a=1); 8 pivot samples then middle-only -> FOLLOW.
REQ-033 Then 2 all-high, 1 middle-only, 3 all-high -> only one further node; node_count=2, code 11 -> done=1, motors 0.
REQ-034 Right=1500, left=500 sample -> dc1=10, dc2=2; path write with busy=1 -> memory unchanged on readback run.
REQ-035 Reset asserted mid-TURN between clock edges -> outputs 0, IDLE immediately; path preserved, next start replays same path.
REQ-036 With LF_LOST_RECOVERY_EN: 16 all-low samples -> SEARCH, dc=6/6; middle=1300 -> FOLLOW; without macro -> outputs held.

Source files
------------

// File: rtl/node_path_sequencer.sv
// node_path_sequencer: line follower that replays a 16-entry path of node codes.
// Optional lost-line search is built only when LF_LOST_RECOVERY_EN is defined.
module node_path_sequencer #(
    parameter int THRESH_HI  = 1200,
    parameter int THRESH_LO  = 700,
    parameter int DEBOUNCE   = 3,
    parameter int TURN_MIN   = 8,
    parameter int LOST_LIMIT = 16
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic [11:0] left,
    input  logic [11:0] middle,
    input  logic [11:0] right,
    input  logic        sample_valid,
    input  logic        path_wr_en,
    input  logic [3:0]  path_wr_addr,
    input  logic [1:0]  path_wr_data,
    input  logic        start,
    output logic        m1_a,
    output logic        m1_b,
    output logic        m2_a,
    output logic        m2_b,
    output logic [3:0]  dc1,
    output logic [3:0]  dc2,
    output logic [3:0]  node_count,
    output logic        busy,
    output logic        done,
    output logic [2:0]  fsm_state
);

    // One shared counter covers debounce, pivot time and the lost-line run.
    localparam int MAX_A   = (DEBOUNCE > TURN_MIN) ? DEBOUNCE : TURN_MIN;
    localparam int CNT_MAX = (MAX_A > LOST_LIMIT) ? MAX_A : LOST_LIMIT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
    localparam logic [CW-1:0] DEB_L   = CW'(DEBOUNCE);
    localparam logic [CW-1:0] TURN_L  = CW'(TURN_MIN);
    localparam logic [11:0]   HI_L    = 12'(THRESH_HI);
    localparam logic [11:0]   LO_L    = 12'(THRESH_LO);

    localparam logic [1:0] M_FWD  = 2'b10;
    localparam logic [1:0] M_REV  = 2'b01;
    localparam logic [1:0] M_STOP = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FOLLOW  = 3'd1,
        S_CONFIRM = 3'd2,
        S_TURN    = 3'd3,
        S_EXIT    = 3'd4,
        S_DONE    = 3'd5,
        S_SEARCH  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [3:0]      node_count_q, node_count_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            turn_right_q, turn_right_d;
    logic            past_end_q, past_end_d;
    logic [1:0]      m1_q, m1_d, m2_q, m2_d;
    logic [3:0]      dc1_q, dc1_d, dc2_q, dc2_d;
    logic [1:0]      path_mem [16];
    logic [1:0]      code;

    // sample_valid and start are single-cycle strobes with no back-pressure:
    // each is consumed on the clock edge where it is high, never stalled or queued.
    logic hi_l, hi_m, hi_r, lo_l, lo_r;
    logic mid_only, all_hi, corr_right, corr_left;

    assign hi_l       = left > HI_L;
    assign hi_m       = middle > HI_L;
    assign hi_r       = right > HI_L;
    assign lo_l       = left < LO_L;
    assign lo_r       = right < LO_L;
    assign mid_only   = hi_m && lo_l && lo_r;
    assign all_hi     = hi_l && hi_m && hi_r;
    assign corr_right = hi_r && lo_l;
    assign corr_left  = hi_l && lo_r;
    assign cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
    assign code       = path_mem[node_count_q];

`ifdef LF_LOST_RECOVERY_EN
    localparam logic [CW-1:0] LOST_L = CW'(LOST_LIMIT);
    logic lo_m, all_lo;
    logic last_right_q, last_right_d;
    assign lo_m   = middle < LO_L;
    assign all_lo = lo_l && lo_m && lo_r;
`endif

    // Path memory is deliberately outside the reset domain so a stored route survives reset.
    always_ff @(posedge clk_50M) begin
        if (path_wr_en && !busy_q) begin
            path_mem[path_wr_addr] <= path_wr_data;
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            node_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            turn_right_q <= 1'b0;
            past_end_q   <= 1'b0;
            m1_q         <= M_STOP;
            m2_q         <= M_STOP;
            dc1_q        <= '0;
            dc2_q        <= '0;
`ifdef LF_LOST_RECOVERY_EN
            last_right_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            node_count_q <= node_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            turn_right_q <= turn_right_d;
            past_end_q   <= past_end_d;
            m1_q         <= m1_d;
            m2_q         <= m2_d;
            dc1_q        <= dc1_d;
            dc2_q        <= dc2_d;
`ifdef LF_LOST_RECOVERY_EN
            last_right_q <= last_right_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        node_count_d = node_count_q;
        busy_d       = busy_q;
        done_d       = done_q;
        turn_right_d = turn_right_q;
        past_end_d   = past_end_q;
`ifdef LF_LOST_RECOVERY_EN
        last_right_d = last_right_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_FOLLOW;
                    cnt_d        = '0;
                    node_count_d = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    past_end_d   = 1'b0;
                end
            end
            S_FOLLOW: begin
                if (sample_valid) begin
                    if (all_hi) begin
                        state_d = S_CONFIRM;
                        cnt_d   = CW'(1);
                    end else begin
                        cnt_d = '0;
`ifdef LF_LOST_RECOVERY_EN
                        if (corr_right) begin
                            last_right_d = 1'b1;
                        end else if (corr_left) begin
                            last_right_d = 1'b0;
                        end
                        if (all_lo) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= LOST_L) begin
                                state_d = S_SEARCH;
                                cnt_d   = '0;
                            end
                        end
`endif
                    end
                end
            end
            S_CONFIRM: begin
                if (sample_valid) begin
                    if (!all_hi) begin
                        state_d = S_FOLLOW;
                        cnt_d   = '0;
                    end else if (cnt_inc >= DEB_L) begin
                        cnt_d = '0;
                        // After index 15 has run, any further node ends the route.
                        if (past_end_q) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            node_count_d = (node_count_q == 4'd15) ? node_count_q : node_count_q + 4'd1;
                            past_end_d   = (node_count_q == 4'd15);
                            case (code)
                                2'b00: state_d = S_EXIT;
                                2'b01: begin
                                    state_d      = S_TURN;
                                    turn_right_d = 1'b0;
                                end
                                2'b10: begin
                                    state_d      = S_TURN;
                                    turn_right_d = 1'b1;
                                end
                                default: begin
                                    state_d = S_DONE;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_TURN: begin
                if (sample_valid) begin
                    if ((cnt_q >= TURN_L) && mid_only) begin
                        state_d = S_FOLLOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_EXIT: begin
                if (sample_valid && !all_hi) begin
                    state_d = S_FOLLOW;
                    cnt_d   = '0;
                end
            end
`ifdef LF_LOST_RECOVERY_EN
            S_SEARCH: begin
                if (sample_valid && hi_m) begin
                    state_d = S_FOLLOW;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Drive outputs are registered against the next state so they hold between strobes.
    always_comb begin
        m1_d  = m1_q;
        m2_d  = m2_q;
        dc1_d = dc1_q;
        dc2_d = dc2_q;
        case (state_d)
            S_FOLLOW, S_CONFIRM: begin
                if (sample_valid) begin
                    if (mid_only) begin
                        m1_d = M_FWD; m2_d = M_FWD; dc1_d = 4'd8;  dc2_d = 4'd8;
                    end else if (corr_right) begin
                        m1_d = M_FWD; m2_d = M_FWD; dc1_d = 4'd10; dc2_d = 4'd2;
                    end else if (corr_left) begin
                        m1_d = M_FWD; m2_d = M_FWD; dc1_d = 4'd2;  dc2_d = 4'd10;
                    end
                end
            end
            S_TURN: begin
                m1_d  = turn_right_d ? M_FWD : M_REV;
                m2_d  = turn_right_d ? M_REV : M_FWD;
                dc1_d = 4'd8;
                dc2_d = 4'd8;
            end
            S_EXIT: begin
                m1_d = M_FWD; m2_d = M_FWD; dc1_d = 4'd8; dc2_d = 4'd8;
            end
`ifdef LF_LOST_RECOVERY_EN
            S_SEARCH: begin
                m1_d  = last_right_d ? M_FWD : M_REV;
                m2_d  = last_right_d ? M_REV : M_FWD;
                dc1_d = 4'd6;
                dc2_d = 4'd6;
            end
`endif
            default: begin
                m1_d = M_STOP; m2_d = M_STOP; dc1_d = '0; dc2_d = '0;
            end
        endcase
    end

    assign {m1_a, m1_b} = m1_q;
    assign {m2_a, m2_b} = m2_q;
    assign dc1          = dc1_q;
    assign dc2          = dc2_q;
    assign node_count   = node_count_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_node_path_sequencer.sv
// Directed bench for node_path_sequencer: route replay, debounce, pivot timing,
// busy write protection, mid-run reset and end-of-path handling.
module tb_node_path_sequencer;

    localparam logic [11:0] V_LO = 12'd500;
    localparam logic [11:0] V_HI = 12'd1500;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_FOLLOW = 3'd1, ST_CONFIRM = 3'd2,
                           ST_TURN = 3'd3, ST_EXIT = 3'd4, ST_DONE = 3'd5, ST_SEARCH = 3'd6;
    localparam logic [1:0] FWD = 2'b10, REV = 2'b01, STP = 2'b00;

    logic        clk_50M = 1'b0;
    logic        reset;
    logic [11:0] left, middle, right;
    logic        sample_valid, path_wr_en, start;
    logic [3:0]  path_wr_addr;
    logic [1:0]  path_wr_data;
    logic        m1_a, m1_b, m2_a, m2_b, busy, done;
    logic [3:0]  dc1, dc2, node_count;
    logic [2:0]  fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    node_path_sequencer dut (
        .clk_50M(clk_50M), .reset(reset),
        .left(left), .middle(middle), .right(right), .sample_valid(sample_valid),
        .path_wr_en(path_wr_en), .path_wr_addr(path_wr_addr), .path_wr_data(path_wr_data),
        .start(start),
        .m1_a(m1_a), .m1_b(m1_b), .m2_a(m2_a), .m2_b(m2_b),
        .dc1(dc1), .dc2(dc2), .node_count(node_count), .busy(busy), .done(done),
        .fsm_state(fsm_state)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_drive(input string tag, input logic [1:0] m1, input logic [1:0] m2,
                               input logic [3:0] d1, input logic [3:0] d2);
        check({tag, "_m1"}, {m1_a, m1_b}, m1);
        check({tag, "_m2"}, {m2_a, m2_b}, m2);
        check({tag, "_dc1"}, dc1, d1);
        check({tag, "_dc2"}, dc2, d2);
    endtask

    // One clock of stimulus driven at the falling edge; outputs are read 1ns after the rising edge.
    task automatic step(input logic [11:0] l, input logic [11:0] m, input logic [11:0] r,
                        input logic sv, input logic we, input logic [3:0] wa,
                        input logic [1:0] wd, input logic st);
        @(negedge clk_50M);
        left = l; middle = m; right = r;
        sample_valid = sv; path_wr_en = we; path_wr_addr = wa; path_wr_data = wd; start = st;
        @(posedge clk_50M);
        #1;
        sample_valid = 1'b0; path_wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic samp(input logic [11:0] l, input logic [11:0] m, input logic [11:0] r);
        step(l, m, r, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
    endtask

    task automatic samp_n(input logic [11:0] l, input logic [11:0] m, input logic [11:0] r, input int n);
        for (int k = 0; k < n; k++) samp(l, m, r);
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] d);
        step(V_LO, V_LO, V_LO, 1'b0, 1'b1, a, d, 1'b0);
    endtask

    task automatic go();
        step(V_LO, V_LO, V_LO, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        left = '0; middle = '0; right = '0;
        sample_valid = 1'b0; path_wr_en = 1'b0; path_wr_addr = '0; path_wr_data = '0; start = 1'b0;
        repeat (2) @(posedge clk_50M);
        #1;
        check("rst_state", fsm_state, ST_IDLE);
        check_drive("rst", STP, STP, 4'd0, 4'd0);
        check("rst_cnt", node_count, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk_50M);
        reset = 1'b0;

        // Route: left turn, then stop.
        for (int i = 0; i < 16; i++) wr(4'(i), (i == 0) ? 2'b01 : 2'b11);
        go();
        check("start_busy", busy, 1'b1);
        check("start_state", fsm_state, ST_FOLLOW);
        samp(V_LO, V_HI, V_LO);
        check_drive("mid", FWD, FWD, 4'd8, 4'd8);
        step(V_LO, V_LO, V_HI, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
        check_drive("nostrobe_hold", FWD, FWD, 4'd8, 4'd8);
        samp(V_LO, V_LO, V_HI);
        check_drive("corr_r", FWD, FWD, 4'd10, 4'd2);
        samp(V_HI, V_LO, V_LO);
        check_drive("corr_l", FWD, FWD, 4'd2, 4'd10);
`ifdef LF_LOST_RECOVERY_EN
        samp_n(V_LO, V_LO, V_LO, 15);
        check("lost15_state", fsm_state, ST_FOLLOW);
        samp(V_LO, V_LO, V_LO);
        check("lost16_state", fsm_state, ST_SEARCH);
        check_drive("search", REV, FWD, 4'd6, 4'd6);
        check("search_cnt", node_count, 4'd0);
`else
        samp_n(V_LO, V_LO, V_LO, 20);
        check("lost_state", fsm_state, ST_FOLLOW);
        check_drive("lost_hold", FWD, FWD, 4'd2, 4'd10);
`endif
        samp(V_LO, 12'd1300, V_LO);
        check("reacq_state", fsm_state, ST_FOLLOW);
        check_drive("reacq", FWD, FWD, 4'd8, 4'd8);

        samp(V_HI, V_HI, V_HI);
        check("deb1_state", fsm_state, ST_CONFIRM);
        samp(V_HI, V_HI, V_HI);
        check("deb2_state", fsm_state, ST_CONFIRM);
        check("deb2_cnt", node_count, 4'd0);
        samp(V_HI, V_HI, V_HI);
        check("node1_state", fsm_state, ST_TURN);
        check("node1_cnt", node_count, 4'd1);
        check_drive("turn_l", REV, FWD, 4'd8, 4'd8);
        samp_n(V_LO, V_HI, V_LO, 8);
        check("turn8_state", fsm_state, ST_TURN);
        samp(V_LO, V_HI, V_LO);
        check("turn9_state", fsm_state, ST_FOLLOW);
        check_drive("after_turn", FWD, FWD, 4'd8, 4'd8);

        samp_n(V_HI, V_HI, V_HI, 2);
        samp(V_LO, V_HI, V_LO);
        check("bounce_state", fsm_state, ST_FOLLOW);
        check("bounce_cnt", node_count, 4'd1);
        samp_n(V_HI, V_HI, V_HI, 3);
        check("stop_state", fsm_state, ST_DONE);
        check("stop_cnt", node_count, 4'd2);
        check("stop_done", done, 1'b1);
        check("stop_busy", busy, 1'b0);
        check_drive("stop", STP, STP, 4'd0, 4'd0);

        // Writes during a run must not reach the path memory.
        go();
        check("run2_done", done, 1'b0);
        check("run2_cnt", node_count, 4'd0);
        wr(4'd0, 2'b10);
        step(V_HI, V_HI, V_HI, 1'b1, 1'b1, 4'd1, 2'b00, 1'b0);
        samp_n(V_HI, V_HI, V_HI, 2);
        check_drive("busywr_turn", REV, FWD, 4'd8, 4'd8);
        samp_n(V_LO, V_HI, V_LO, 9);
        samp_n(V_HI, V_HI, V_HI, 3);
        check("busywr_state", fsm_state, ST_DONE);
        check("busywr_cnt", node_count, 4'd2);

        // Write honoured alongside a strobe while idle; then reset mid-turn.
        step(V_LO, V_HI, V_LO, 1'b1, 1'b1, 4'd0, 2'b10, 1'b0);
        check_drive("done_hold", STP, STP, 4'd0, 4'd0);
        go();
        samp_n(V_HI, V_HI, V_HI, 3);
        check_drive("turn_r", FWD, REV, 4'd8, 4'd8);
        samp_n(V_LO, V_HI, V_LO, 2);
        @(negedge clk_50M);
        #2 reset = 1'b1;
        #1;
        check("arst_state", fsm_state, ST_IDLE);
        check_drive("arst", STP, STP, 4'd0, 4'd0);
        check("arst_cnt", node_count, 4'd0);
        check("arst_busy", busy, 1'b0);
        @(negedge clk_50M);
        reset = 1'b0;
        go();
        samp_n(V_HI, V_HI, V_HI, 3);
        check("replay_state", fsm_state, ST_TURN);
        check("replay_cnt", node_count, 4'd1);
        check_drive("replay", FWD, REV, 4'd8, 4'd8);
        @(negedge clk_50M);
        reset = 1'b1;
        @(negedge clk_50M);
        reset = 1'b0;

        // Sixteen straight nodes, then one more node must end the route.
        for (int i = 0; i < 16; i++) wr(4'(i), 2'b00);
        go();
        for (int i = 0; i < 16; i++) begin
            samp_n(V_HI, V_HI, V_HI, 3);
            check("straight_state", fsm_state, ST_EXIT);
            check("straight_cnt", node_count, (i < 15) ? 4'(i + 1) : 4'd15);
            if (i == 0) begin
                check_drive("exit", FWD, FWD, 4'd8, 4'd8);
                samp(V_HI, V_HI, V_HI);
                check("exit_allhi", fsm_state, ST_EXIT);
            end
            samp(V_LO, V_HI, V_LO);
            check("exit_leave", fsm_state, ST_FOLLOW);
        end
        samp_n(V_HI, V_HI, V_HI, 3);
        check("end_state", fsm_state, ST_DONE);
        check("end_done", done, 1'b1);
        check("end_cnt", node_count, 4'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
